matmul_seq_ctrl: RTL and testbench
==================================

# matmul_seq_ctrl

Sequencer for the 8x8 matrix-multiply datapath. On `start`, it walks the output matrix C = A × B in row-major order. It issues read addresses to the two single-port operand RAMs (A and B, 64×8, registered read, 1-cycle latency), accumulates the eight products per element, and writes each 19-bit result to the result RAM (C). The block is fully pipelined: one operand pair per cycle and one C write every 8 cycles.

## Interface
Parameters:
- `DW`, 8: operand width.
- `LOG2N`, 3: log2 of matrix dimension (N = 8).
- `CW`, 2*DW+LOG2N (19): result width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a multiply; sampled only in IDLE.
- `busy`, out, 1: high from the cycle after `start` is accepted through the final C write.
- `done`, out, 1: one-cycle pulse after the final C write.
- `a_addr`, out, 2*LOG2N: RAM A read address = i*N + k.
- `a_data`, in, DW: RAM A registered read data.
- `b_addr`, out, 2*LOG2N: RAM B read address = k*N + j.
- `b_data`, in, DW: RAM B registered read data.
- `c_addr`, out, 2*LOG2N: RAM C write address = i*N + j.
- `c_data`, out, CW: result element.
- `c_wr`, out, 1: RAM C write enable, one cycle per element.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: issue operand addresses.
  - FLUSH: final accumulate and write.
  - DONE: signal completion.
- IDLE→RUN when `start`=1; counters i=j=k=0; accumulator cleared.
- RUN behaviour:
  - Each cycle, drive `a_addr`/`b_addr` from the counters (combinational from the counter registers); k increments.
  - On k wrap 7→0, j increments; on j wrap, i increments.
  - After issuing i=j=k=7, go to FLUSH.
- Data pipeline:
  - `vld_d` is a 1-cycle delayed copy of "address issued".
  - `last_d` is a delayed copy of k==7.
  - i/j are delayed into `ci`/`cj`.
- Accumulate: each cycle with `vld_d`, prod = a_data*b_data (2*DW bits, zero-extended to CW).
  - `last_d`=0: acc ← acc + prod.
  - `last_d`=1: `c_data` = acc + prod, `c_wr`=1, `c_addr` = ci*N+cj, and acc ← 0 in the same edge (no bubble between elements).
- FLUSH: performs the last write (element 63), then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE; `busy`=0 in DONE.
- `start` during RUN/FLUSH/DONE is ignored. A `start` held high in the IDLE cycle after DONE starts a new run.
- Arithmetic:
  - Unsigned by default.
  - The maximum sum is 8·255·255 = 520200, which fits in CW=19; there is no overflow handling.
- Reset, asserted at any time: state=IDLE, counters=0, acc=0, `vld_d`/`last_d`=0.
  - Outputs `busy`=0, `done`=0, `c_wr`=0, `c_data`=0, all addresses 0, effective immediately (async).
  - A partially written C is left as is.

## Timing
- Edge E0 samples `start`=1. Cycle 1: RUN, `busy`=1, addresses for (0,0,0).
- Operand pair issued in cycle t → product accumulated at the end of cycle t+1.
- First `c_wr` in cycle 9 (element 0). Element e is written in cycle 8e+9.
- Last write (e=63) in cycle 513 (FLUSH). `done` in cycle 514. IDLE in cycle 515.
- Throughput: 512 operand cycles per matrix, 100% RAM read utilization.
- `c_wr` is never asserted outside cycles 8e+9.
- `a_addr`/`b_addr` outside RUN hold their last values; RAM reads there are don't-care.

## Configuration
- `MATMUL_SIGNED_EN`:
  - Defined: operands are two's complement. Products are sign-extended to CW before accumulation, and `c_data` is signed. The extreme value 8·(−128)·(−128) = 131072 fits in the signed 19-bit range.
  - Undefined: unsigned operands, zero extension.
  - Counters, FSM and timing are identical in both cases.

## Structure
- Shared package `matmul_pkg`: DW, LOG2N, N, CW constants; state enum (IDLE, RUN, FLUSH, DONE); address-width constant 2*LOG2N.
- One sub-module, `matmul_mac`:
  - Multiplier plus accumulator.
  - Inputs: `vld`, `last`, `a`, `b`.
  - Outputs: `sum`, `sum_vld`.
  - Signedness follows `MATMUL_SIGNED_EN`.
- FSM, i/j/k counters, and delay registers stay in `matmul_seq_ctrl`.

## Test plan
- Identity: A = I (diag 1), B[r][c] = r*8+c, start pulse → 64 writes with C[x] = x, at cycles 8x+9; `done` at cycle 514.
- Saturating values, unsigned: A = B = all 255 → every `c_data` = 520200 (0x7F008); no wrap.
- Signed, with `MATMUL_SIGNED_EN`: A = B = all 0x80 → every `c_data` = 131072. A all 0x80, B all 0x7F → every `c_data` = −130048.
- `start` held high for the whole run → exactly one 64-write sequence, then a second run begins the cycle after IDLE is re-entered.
- Reset mid-run: assert `rst_n`=0 in cycle 200 → `busy`/`c_wr`/`done` low immediately. Then start again → full correct 64-element result with no residue in the accumulator.
- Address trace: check `a_addr`/`b_addr` in cycles 1–16 are (0,0),(1,8),…,(7,56),(0,1),(1,9),…,(7,57).

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and FSM state type for the 8x8 matrix-multiply sequencer.
package matmul_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned LOG2N = 3;
  localparam int unsigned N     = 1 << LOG2N;
  localparam int unsigned CW    = 2*DW + LOG2N;
  localparam int unsigned AW    = 2*LOG2N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: multiplier plus accumulator, emits one dot-product sum per element.
// Build option: MATMUL_SIGNED_EN selects two's-complement operands (sign-extended products).
module matmul_mac #(
  parameter int unsigned DW = matmul_pkg::DW,
  parameter int unsigned CW = matmul_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          vld,
  input  logic          last,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [CW-1:0] sum,
  output logic          sum_vld
);

  logic [CW-1:0] r_acc;
  logic [CW-1:0] w_prod;

`ifdef MATMUL_SIGNED_EN
  logic [2*DW-1:0] w_a_ext;
  logic [2*DW-1:0] w_b_ext;
  logic [2*DW-1:0] w_prod_raw;

  // Low 2*DW bits of the sign-extended product are the exact signed product.
  assign w_a_ext    = {{DW{a[DW-1]}}, a};
  assign w_b_ext    = {{DW{b[DW-1]}}, b};
  assign w_prod_raw = w_a_ext * w_b_ext;
  assign w_prod     = {{(CW-2*DW){w_prod_raw[2*DW-1]}}, w_prod_raw};
`else
  assign w_prod = CW'((2*DW)'(a) * (2*DW)'(b));
`endif

  assign sum     = r_acc + w_prod;
  assign sum_vld = vld & last;

  // The last product of an element is emitted via sum and the accumulator restarts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (vld) begin
      if (last) begin
        r_acc <= '0;
      end else begin
        r_acc <= sum;
      end
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: walks C = A x B row-major, one operand pair per cycle, one C write per 8 cycles.
// Build option: MATMUL_SIGNED_EN (two's-complement operands, handled in matmul_mac).
module matmul_seq_ctrl #(
  parameter int unsigned DW    = matmul_pkg::DW,
  parameter int unsigned LOG2N = matmul_pkg::LOG2N,
  parameter int unsigned CW    = 2*DW + LOG2N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*LOG2N-1:0]   a_addr,
  input  logic [DW-1:0]        a_data,
  output logic [2*LOG2N-1:0]   b_addr,
  input  logic [DW-1:0]        b_data,
  output logic [2*LOG2N-1:0]   c_addr,
  output logic [CW-1:0]        c_data,
  output logic                 c_wr
);

  import matmul_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LOG2N-1:0]  r_i;
  logic [LOG2N-1:0]  r_j;
  logic [LOG2N-1:0]  r_k;
  logic [LOG2N-1:0]  r_ci;
  logic [LOG2N-1:0]  r_cj;
  logic              r_vld_d;
  logic              r_last_d;
  logic              w_start_acc;
  logic              w_issue;
  logic              w_last_issue;
  logic [CW-1:0]     w_sum;
  logic              w_sum_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_acc  = 1'b0;
    w_issue      = 1'b0;
    w_last_issue = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_start_acc = 1'b1;
        end
      end
      RUN: begin
        w_issue = 1'b1;
        if (&{r_i, r_j, r_k}) begin
          w_last_issue = 1'b1;
          w_state_nxt  = FLUSH;
        end
      end
      FLUSH:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counters freeze on the final issue so the addresses hold (63, 63) until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (w_start_acc) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (w_issue && !w_last_issue) begin
      r_k <= r_k + LOG2N'(1);
      if (&r_k) begin
        r_j <= r_j + LOG2N'(1);
        if (&r_j) begin
          r_i <= r_i + LOG2N'(1);
        end
      end
    end
  end

  // Delay line aligning control with the registered RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_d  <= 1'b0;
      r_last_d <= 1'b0;
      r_ci     <= '0;
      r_cj     <= '0;
    end else begin
      r_vld_d  <= w_issue;
      r_last_d <= w_issue && (&r_k);
      if (w_issue) begin
        r_ci <= r_i;
        r_cj <= r_j;
      end
    end
  end

  matmul_mac #(
    .DW (DW),
    .CW (CW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_start_acc),
    .vld     (r_vld_d),
    .last    (r_last_d),
    .a       (a_data),
    .b       (b_data),
    .sum     (w_sum),
    .sum_vld (w_sum_vld)
  );

  assign a_addr = {r_i, r_k};
  assign b_addr = {r_k, r_j};
  assign c_addr = {r_ci, r_cj};
  assign c_wr   = w_sum_vld;
  assign c_data = w_sum_vld ? w_sum : '0;
  assign busy   = (r_state == RUN) || (r_state == FLUSH);
  assign done   = (r_state == DONE);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: directed runs of matmul_seq_ctrl checked every cycle against a matrix-level model.
module tb_matmul_seq_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 19;
  localparam int unsigned AW = 6;
  localparam int LAST_T = 515;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic [CW-1:0] c_data;
  logic          c_wr;

  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];

  // compare-process state
  int n_pass = 0;
  int n_chk = 0;
  int t = 0;
  bit track = 1'b0;
  int run_cnt = 0;
  int seen_rst = 0;
  int idle_addr = 0;
  bit pinned = 1'b0;
  int exp_c [64];

  // stimulus-process state
  int rst_cnt;
  int n_pins;
  int pin_idx [2];
  int pin_val [2];

  always #5 clk = ~clk;

  matmul_seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .a_addr (a_addr),
    .a_data (a_data),
    .b_addr (b_addr),
    .b_data (b_data),
    .c_addr (c_addr),
    .c_data (c_data),
    .c_wr   (c_wr)
  );

  // operand RAMs with one-cycle registered read
  always @(posedge clk) begin
    a_data <= mem_a[a_addr];
    b_data <= mem_b[b_addr];
  end

  function automatic int opv(input logic [DW-1:0] x);
`ifdef MATMUL_SIGNED_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  // operand pair n = t-1 walks (i, j, k) in row-major order; after the run it holds (7,7,7)
  function automatic int exp_a(input int tt);
    int n;
    n = (tt <= 512) ? tt - 1 : 511;
    return (n / 64) * 8 + (n % 8);
  endfunction

  function automatic int exp_b(input int tt);
    int n;
    n = (tt <= 512) ? tt - 1 : 511;
    return (n % 8) * 8 + (n / 8) % 8;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk = n_chk + 1;
    if (act === req) n_pass = n_pass + 1;
    else $display("FAIL %s t=%0d run=%0d got=%0d want=%0d", nm, t, run_cnt, act, req);
  endtask

  task automatic begin_run();
    t = 0;
    track = 1'b1;
    run_cnt = run_cnt + 1;
    for (int e = 0; e < 64; e++) begin
      int s;
      s = 0;
      for (int k = 0; k < 8; k++) s = s + opv(mem_a[(e / 8) * 8 + k]) * opv(mem_b[k * 8 + (e % 8)]);
      exp_c[e] = s;
    end
    for (int q = 0; q < n_pins; q++) chk("model_c_pin", exp_c[pin_idx[q]], pin_val[q]);
    if (!pinned) begin
      pinned = 1'b1;
      chk("model_a_t2", exp_a(2), 1);
      chk("model_b_t2", exp_b(2), 8);
      chk("model_a_t9", exp_a(9), 0);
      chk("model_b_t9", exp_b(9), 1);
      chk("model_b_t16", exp_b(16), 57);
    end
  endtask

  task automatic check_cycle();
    bit wr_exp;
    int e;
    wr_exp = (t >= 9) && (t <= 513) && (((t - 9) % 8) == 0);
    chk("busy", busy, (t <= 513));
    chk("done", done, (t == 514));
    chk("c_wr", c_wr, wr_exp);
    if (wr_exp) begin
      e = (t - 9) / 8;
      chk("c_addr", 32'(c_addr), e);
      chk("c_data", 32'(c_data), exp_c[e] & 32'h7FFFF);
    end
    chk("a_addr", 32'(a_addr), exp_a(t));
    chk("b_addr", 32'(b_addr), exp_b(t));
  endtask

  // single compare process: all DUT outputs checked on every falling edge
  always @(negedge clk) begin
    if (rst_cnt != seen_rst) begin
      seen_rst = rst_cnt;
      track = 1'b0;
      idle_addr = 0;
    end
    if (!rst_n) begin
      track = 1'b0;
      idle_addr = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_c_wr", c_wr, 0);
      chk("rst_c_data", 32'(c_data), 0);
      chk("rst_a_addr", 32'(a_addr), 0);
      chk("rst_b_addr", 32'(b_addr), 0);
      chk("rst_c_addr", 32'(c_addr), 0);
    end else if (track) begin
      t = t + 1;
      check_cycle();
      if (t == LAST_T) begin
        idle_addr = 63;
        if (start) begin_run();
        else track = 1'b0;
      end
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_c_wr", c_wr, 0);
      chk("idle_a_addr", 32'(a_addr), idle_addr);
      chk("idle_b_addr", 32'(b_addr), idle_addr);
      chk("idle_c_addr", 32'(c_addr), idle_addr);
      if (start) begin_run();
    end
  end

  task automatic wait_track_done();
    int n;
    n = 0;
    while (track && n < 1200) begin
      @(posedge clk);
      n = n + 1;
    end
    if (track) begin
      $display("FAIL run_timeout run=%0d t=%0d", run_cnt, t);
      $fatal(1, "run did not complete");
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_run();
    pulse_start();
    wait_track_done();
  endtask

  task automatic load_pattern();
    for (int x = 0; x < 64; x++) begin
      mem_a[x] = DW'((x * 7 + 3) % 256);
      mem_b[x] = DW'((x * 13 + 5) % 256);
    end
    n_pins = 1;
    pin_idx[0] = 0;
`ifdef MATMUL_SIGNED_EN
    pin_val[0] = 2956;
`else
    pin_val[0] = 28556;
`endif
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    start = 1'b0;
    rst_cnt = 0;
    n_pins = 0;
    pin_idx[0] = 0; pin_idx[1] = 0;
    pin_val[0] = 0; pin_val[1] = 0;
    for (int x = 0; x < 64; x++) begin
      mem_a[x] = '0;
      mem_b[x] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // identity A, B[r][c] = r*8+c -> C[x] = x
    for (int x = 0; x < 64; x++) begin
      mem_a[x] = DW'((x / 8) == (x % 8));
      mem_b[x] = DW'(x);
    end
    n_pins = 2;
    pin_idx[0] = 37; pin_val[0] = 37;
    pin_idx[1] = 63; pin_val[1] = 63;
    do_run();

`ifdef MATMUL_SIGNED_EN
    for (int x = 0; x < 64; x++) begin
      mem_a[x] = 8'h80;
      mem_b[x] = 8'h80;
    end
    n_pins = 1;
    pin_idx[0] = 5; pin_val[0] = 131072;
    do_run();
    for (int x = 0; x < 64; x++) mem_b[x] = 8'h7F;
    pin_idx[0] = 40; pin_val[0] = -130048;
    do_run();
`else
    for (int x = 0; x < 64; x++) begin
      mem_a[x] = 8'hFF;
      mem_b[x] = 8'hFF;
    end
    n_pins = 1;
    pin_idx[0] = 63; pin_val[0] = 520200;
    do_run();
`endif

    load_pattern();
    do_run();

    // start held high: one full run, then a second beginning right after IDLE
    base = run_cnt;
    @(posedge clk); #1 start = 1'b1;
    n = 0;
    while (run_cnt < base + 2 && n < 1200) begin
      @(posedge clk);
      n = n + 1;
    end
    if (run_cnt < base + 2) begin
      $display("FAIL hold_second_run run=%0d", run_cnt);
      $fatal(1, "second run never began");
    end
    #1 start = 1'b0;
    wait_track_done();

    // short asynchronous reset pulse inside cycle 200, no clock edge while low
    pulse_start();
    n = 0;
    while (!(track && t == 200) && n < 1000) begin
      @(negedge clk); #1;
      n = n + 1;
    end
    if (!(track && t == 200)) begin
      $display("FAIL reset_cycle_reach t=%0d", t);
      $fatal(1, "cycle 200 not reached");
    end
    rst_n = 1'b0;
    rst_cnt = rst_cnt + 1;
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    do_run();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
